// File: rtl/count_readout_serializer.sv
// count_readout_serializer
// Snapshots NCH channel counters on request, optionally pulses a clear back to
// the counters, and streams the frame {HDR, ch0 MSB..LSB, ..., chN-1 MSB..LSB}
// one byte per accepted valid/ready transfer.
// Optional build macro: READOUT_CHECKSUM_EN appends an XOR checksum byte that
// covers every snapshot byte (the header is excluded).
module count_readout_serializer #(
  parameter int          NCH = 4,
  parameter int          CW  = 16,
  parameter logic [7:0]  HDR = 8'hA5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic [NCH*CW-1:0] cnt_in,
  input  logic              start,
  input  logic              clr_en,
  output logic              clr_out,
  output logic [7:0]        dout,
  output logic              dvalid,
  input  logic              dready,
  output logic              busy
);

  localparam int BPC   = CW / 8;
  localparam int NDATA = NCH * BPC;
`ifdef READOUT_CHECKSUM_EN
  localparam int FLEN  = NDATA + 2;
`else
  localparam int FLEN  = NDATA + 1;
`endif
  localparam int IW    = $clog2(FLEN + 1);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t              state, state_n;
  logic [IW-1:0]       idx, idx_n;
  logic [NCH*CW-1:0]   snap, snap_n;
  logic [7:0]          dout_n;
  logic                dvalid_n, busy_n, clr_n;
  logic [IW-1:0]       idx_inc;
  logic [7:0]          next_byte;
  logic                last_byte;

  // Pick the byte that follows the current index out of the frozen snapshot.
  always_comb begin
    idx_inc   = idx + IW'(1);
    last_byte = (idx == IW'(FLEN - 1));
    next_byte = 8'h00;
    for (int k = 0; k < NDATA; k++) begin
      if (idx_inc == IW'(k + 1)) begin
        next_byte = snap[((k / BPC) * CW) + ((BPC - 1 - (k % BPC)) * 8) +: 8];
      end
    end
`ifdef READOUT_CHECKSUM_EN
    if (idx_inc == IW'(NDATA + 1)) begin
      next_byte = 8'h00;
      for (int k = 0; k < NDATA; k++) begin
        next_byte = next_byte ^ snap[k*8 +: 8];
      end
    end
`endif
  end

  // Next-state logic; with ena low every register simply holds.
  always_comb begin
    state_n  = state;
    idx_n    = idx;
    snap_n   = snap;
    dout_n   = dout;
    dvalid_n = dvalid;
    busy_n   = busy;
    clr_n    = clr_out;
    if (ena) begin
      clr_n = 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            snap_n   = cnt_in;
            clr_n    = clr_en;
            idx_n    = '0;
            dout_n   = HDR;
            dvalid_n = 1'b1;
            busy_n   = 1'b1;
            state_n  = SEND;
          end
        end
        SEND: begin
          if (dready) begin
            if (last_byte) begin
              idx_n    = '0;
              dvalid_n = 1'b0;
              busy_n   = 1'b0;
              state_n  = IDLE;
            end else begin
              idx_n  = idx_inc;
              dout_n = next_byte;
            end
          end
        end
        default: begin
          state_n  = IDLE;
          dvalid_n = 1'b0;
          busy_n   = 1'b0;
        end
      endcase
    end
  end

  // State and registered outputs; reset abandons any partial frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      idx     <= '0;
      snap    <= '0;
      dout    <= 8'h00;
      dvalid  <= 1'b0;
      busy    <= 1'b0;
      clr_out <= 1'b0;
    end else begin
      state   <= state_n;
      idx     <= idx_n;
      snap    <= snap_n;
      dout    <= dout_n;
      dvalid  <= dvalid_n;
      busy    <= busy_n;
      clr_out <= clr_n;
    end
  end

endmodule

// File: doc/count_readout_serializer.md
# count_readout_serializer

- Downstream readout stage for the 4-channel counter top.
- Snapshots all channel counts on request, optionally clears the counters, and streams a framed byte sequence over an 8-bit valid/ready port (mapped onto `uo_out` / `uio`).
- Owns the only readout path from counter state to the chip pins.

## Interface

- `NCH`, 4: number of channels.
- `CW`, 16: counter width per channel. Must be a multiple of 8.
- `HDR`, 8'hA5: frame header byte.

- `clk` in 1: single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `ena` in 1: design enable. When low, all state holds.
- `cnt_in` in NCH*CW: live counts. Channel k is at `[k*CW +: CW]`.
- `start` in 1: readout request. Level-sampled.
- `clr_en` in 1: clear counters after snapshot. Sampled together with `start`.
- `clr_out` out 1: one-cycle pulse that clears the upstream counters.
- `dout` out 8: stream byte.
- `dvalid` out 1: `dout` is valid.
- `dready` in 1: consumer accepts the byte.
- `busy` out 1: a frame is in progress.

## Operation

- States: IDLE, SEND. Reset enters IDLE.
- Reset values: `dout`=0, `dvalid`=0, `busy`=0, `clr_out`=0. Snapshot register and byte index are also 0.
- IDLE, `ena`=1, `start`=1 at a clock edge:
  - Capture all of `cnt_in` into the snapshot.
  - Register `clr_out` = `clr_en`.
  - Set byte index to 0 and go to SEND.
- SEND:
  - `dvalid`=1 and `busy`=1.
  - `dout` = byte[index], where byte[0]=HDR.
  - Then channel 0..NCH-1, each sent MSB byte first.
  - Frame length L = 1 + NCH*CW/8, which is 9 at the defaults.
- Transfer occurs on an edge where `dvalid`&`dready`&`ena`; the index then increments.
- Transfer of the last byte: go to IDLE, with `dvalid`=0 and `busy`=0 from the next cycle.
- `dout` and `dvalid` are stable while `dvalid`=1 and no transfer occurs. `dout` must not change under back-pressure.
- `dout` holds its last value in IDLE. It is don't-care for the consumer.
- `start` during SEND is ignored. There is no queueing.
- `start` held high re-triggers a new frame in the first IDLE cycle after a frame ends.
- `clr_out` is high for exactly one cycle, the cycle after snapshot capture.
  - The counters clear at the following edge.
  - Any count arriving in the capture cycle is lost by definition; this is documented and not masked.
- `ena`=0: no state change, no transfer, no capture. Outputs hold, including `clr_out`. `clr_out` still lasts exactly one enabled cycle.
- `rst_n` low mid-frame: immediate return to IDLE with reset values. The partial frame is discarded and no `clr_out` is issued.

## Timing

- Request to first valid byte: 1 cycle. `start` is sampled at edge N; `dvalid`=1 and `dout`=HDR during cycle N+1.
- Throughput: 1 byte/cycle with `dready` held high. A full frame occupies L cycles of `dvalid`.
- `busy` falls 1 cycle after the last transfer edge.
- Minimum start-to-start spacing: L+1 cycles.
- All outputs are registered. There is no combinational path from `dready` or `start` to any output.

## Configuration

- `READOUT_CHECKSUM_EN`
  - Defined: a trailing byte is appended, so L = 2 + NCH*CW/8 (10 at the defaults). The trailing byte is the XOR of all snapshot bytes, excluding HDR.
  - Undefined: no checksum byte; frame ends after the last channel byte.
- The header, handshake, and timing rules are otherwise identical in both builds.

## Test plan

1. Reset, `cnt_in`={16'h0004,16'h0003,16'h0002,16'h0001} (ch3..ch0), `start` pulse, `dready`=1.
   - Required: bytes A5,00,01,00,02,00,03,00,04 on consecutive cycles.
   - `busy` high for 9 cycles.
   - With `READOUT_CHECKSUM_EN`, a 10th byte 04.
2. Same stimulus with `dready` toggled 1,0,0,1,…
   - Required: `dout` is held during every `dready`=0 cycle, the byte order is unchanged, and no byte is duplicated or skipped.
3. `start` with `clr_en`=1.
   - Required: `clr_out` high for exactly 1 cycle, the cycle after `start`.
   - With `clr_en`=0, `clr_out` is never asserted.
4. `cnt_in` changes to all-FFFF during SEND.
   - Required: the frame still carries the captured values.
   - A second `start` pulse mid-frame produces no extra frame.
5. `rst_n` asserted at byte index 4, then released.
   - Required: outputs are 0 asynchronously and no `clr_out` is issued.
   - A new `start` produces a complete frame beginning with A5.
6. `ena`=0 for 3 cycles mid-frame with `dready`=1.
   - Required: no transfers and outputs frozen; the frame resumes at the same index when `ena`=1.
